// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and MUL sequencer state encoding
package alu_pkg;

  // ALU control codes produced by the ALU control decoder
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_ADDI = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  // Multiply sequencer FSM encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/mul_iter_dp.sv
// rtl/mul_iter_dp.sv - iterative shift-add multiply datapath
module mul_iter_dp #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // Add one shifted copy of mcand per set bit in the low multiplier slice;
  // the sum wraps modulo 2^WIDTH, which is all a low-word MUL needs.
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier[k]) begin
        acc_next = acc_next + (mcand << k);
      end
    end
  end

  // Load operands on start, then consume BITS_PER_CYCLE multiplier bits per step
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= src1;
      mplier <= src2;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - EX-stage MUL sequencer: pipeline stall control and iteration FSM
module mul_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             start;
  logic             step;
  logic [WIDTH-1:0] acc_next;

  // Start only from IDLE, so the same MUL still visible during DONE cannot relaunch
  always_comb begin
    start   = valid_i && (ALUCtrl_i == ALU_MUL) && !flush_i && (state == ST_IDLE);
    step    = (state == ST_BUSY) && !flush_i;
    busy_o  = (state == ST_BUSY);
    done_o  = (state == ST_DONE);
    stall_o = (state == ST_IDLE) ? start : (state == ST_BUSY);
  end

  mul_iter_dp #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_dp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (start),
    .step     (step),
    .src1     (src1_i),
    .src2     (src2_i),
    .acc_next (acc_next)
  );

  // FSM and iteration counter; flush wins over completion so a squashed MUL never writes result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      result_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_BUSY;
            cnt   <= CNT_INIT;
          end
        end
        ST_BUSY: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            result_o <= acc_next;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - scoreboard bench for mul_seq_ctrl at 1 and 4 bits per cycle
module tb_mul_seq_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v1, f1, stall1, busy1, done1;
  logic [2:0]  c1;
  logic [31:0] a1, b1, res1;
  logic        v4, f4, stall4, busy4, done4;
  logic [2:0]  c4;
  logic [31:0] a4, b4, res4;

  mul_seq_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1), .ALUCtrl_i(c1), .flush_i(f1),
    .src1_i(a1), .src2_i(b1), .stall_o(stall1), .busy_o(busy1), .done_o(done1), .result_o(res1)
  );

  mul_seq_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(v4), .ALUCtrl_i(c4), .flush_i(f4),
    .src1_i(a4), .src2_i(b4), .stall_o(stall4), .busy_o(busy4), .done_o(done4), .result_o(res4)
  );

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t m1, m4;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    return p[31:0];
  endfunction

  function automatic logic [2:0] flags(input bit sel);
    return sel ? {stall4, busy4, done4} : {stall1, busy1, done1};
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [2:0] c, input logic f,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      v4 = v; c4 = c; f4 = f; a4 = a; b4 = b;
    end else begin
      v1 = v; c1 = c; f1 = f; a1 = a; b1 = b;
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 1'b0, 64'(res1), 64'(0));
      end else begin
        m1 = q1.pop_front();
        check("dut1_result", res1 == m1.res, 64'(res1), 64'(m1.res));
        check("dut1_done_cycle", cyc == m1.at, 64'(cyc), 64'(m1.at));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        check("dut4_unexpected_done", 1'b0, 64'(res4), 64'(0));
      end else begin
        m4 = q4.pop_front();
        check("dut4_result", res4 == m4.res, 64'(res4), 64'(m4.res));
        check("dut4_done_cycle", cyc == m4.at, 64'(cyc), 64'(m4.at));
      end
    end
  end

  // One complete MUL with the stall window checked cycle by cycle
  task automatic run_mul(input bit sel, input logic [31:0] a, input logic [31:0] b);
    int n;
    int t;
    exp_t e;
    n = sel ? 8 : 32;
    @(negedge clk);
    drive(sel, 1'b1, ALU_MUL, 1'b0, a, b);
    t = cyc;
    e.res = model_mul(a, b);
    e.at  = t + n + 1;
    if (sel) q4.push_back(e); else q1.push_back(e);
    #1;
    check("detect_stall", flags(sel) == 3'b100, 64'(flags(sel)), 64'(3'b100));
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check("busy_window", flags(sel) == 3'b110, 64'(flags(sel)), 64'(3'b110));
      if (i == 1) drive(sel, 1'b0, ALU_ADD, 1'b0, $urandom, $urandom);
    end
    @(negedge clk);
    check("done_flags", flags(sel) == 3'b001, 64'(flags(sel)), 64'(3'b001));
  endtask

  // Idle traffic: non-MUL ops, bubbles, and flushed MULs must never start
  task automatic idle_gap(input bit sel, input int n);
    logic [2:0] c;
    logic       f;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c = 3'($urandom_range(0, 7));
      f = (c == ALU_MUL) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(sel, 1'($urandom_range(0, 1)), c, f, $urandom, $urandom);
      #1;
      check("idle_quiet", flags(sel) == 3'b000, 64'(flags(sel)), 64'(3'b000));
    end
    @(negedge clk);
    drive(sel, 1'b0, ALU_ADD, 1'b0, '0, '0);
  endtask

  initial begin
    logic [31:0] old;
    int t;
    exp_t e;

    rst = 1'b1;
    drive(0, 1'b0, ALU_AND, 1'b0, '0, '0);
    drive(1, 1'b0, ALU_AND, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and pass-through of a non-MUL op
    drive(0, 1'b1, ALU_ADD, 1'b0, 32'd9, 32'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_idle", {flags(0), res1} == 35'd0, 64'({flags(0), res1}), 64'(0));
    end

    // Basic multiply and result hold
    run_mul(0, 32'd7, 32'd6);
    repeat (3) @(negedge clk);
    check("result_hold", res1 == 32'd42, 64'(res1), 64'(42));

    // Signed and wrap cases
    run_mul(0, 32'hFFFF_FFFD, 32'd5);
    run_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mul(0, 32'h8000_0000, 32'd2);
    run_mul(0, 32'd1234, 32'd5678);

    // Flush in BUSY at T+10
    old = res1;
    @(negedge clk);
    drive(0, 1'b1, ALU_MUL, 1'b0, 32'd11, 32'd13);
    t = cyc;
    @(negedge clk);
    drive(0, 1'b0, ALU_ADD, 1'b0, '0, '0);
    repeat (9) @(negedge clk);
    check("flush_cycle", cyc == t + 10, 64'(cyc), 64'(t + 10));
    f1 = 1'b1;
    @(negedge clk);
    f1 = 1'b0;
    check("flush_flags", flags(0) == 3'b000, 64'(flags(0)), 64'(0));
    check("flush_result", res1 == old, 64'(res1), 64'(old));
    repeat (40) @(negedge clk);
    check("flush_result_late", res1 == old, 64'(res1), 64'(old));

    // Reset in BUSY at T+10
    @(negedge clk);
    drive(0, 1'b1, ALU_MUL, 1'b0, 32'd21, 32'd2);
    @(negedge clk);
    drive(0, 1'b0, ALU_ADD, 1'b0, '0, '0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_op", {flags(0), res1} == 35'd0, 64'({flags(0), res1}), 64'(0));
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // MUL held through DONE: no retrigger, second MUL from IDLE at T+34
    @(negedge clk);
    drive(0, 1'b1, ALU_MUL, 1'b0, 32'd5, 32'd9);
    t = cyc;
    e.res = model_mul(32'd5, 32'd9); e.at = t + 33;
    q1.push_back(e);
    repeat (33) @(negedge clk);
    check("held_done_no_stall", flags(0) == 3'b001, 64'(flags(0)), 64'(3'b001));
    @(negedge clk);
    drive(0, 1'b1, ALU_MUL, 1'b0, 32'd3, 32'd4);
    e.res = model_mul(32'd3, 32'd4); e.at = cyc + 33;
    q1.push_back(e);
    #1;
    check("second_stall_start", (flags(0) == 3'b100) && (cyc == t + 34), 64'(flags(0)), 64'(3'b100));
    @(negedge clk);
    drive(0, 1'b0, ALU_ADD, 1'b0, '0, '0);
    repeat (34) @(negedge clk);
    check("second_result", res1 == 32'd12, 64'(res1), 64'(12));

    // Four bits per cycle
    run_mul(1, 32'h1234_5678, 32'h9ABC_DEF0);
    check("bpc4_result", res4 == 32'h242D_2080, 64'(res4), 64'(32'h242D_2080));

    // Randomized traffic on both configurations
    for (int i = 0; i < 12; i++) begin
      idle_gap(0, int'($urandom_range(0, 3)));
      run_mul(0, $urandom, $urandom);
    end
    for (int i = 0; i < 20; i++) begin
      idle_gap(1, int'($urandom_range(0, 3)));
      run_mul(1, $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
    end

    repeat (5) @(negedge clk);
    check("dut1_all_done", q1.size() == 0, 64'(q1.size()), 64'(0));
    check("dut4_all_done", q4.size() == 0, 64'(q4.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
